addr_sequencer: RTL and testbench
=================================

Name: addr_sequencer

Overview:
- Upstream address generator for the on-chip operand/result RAM path. Feeds the registered address/enable delay stage that follows it.
- On a start command it issues a burst of consecutive RAM addresses with a per-address enable. It honours a stall input and drains for a fixed pipeline latency before signalling done.
- Runs in the PLL clock domain of the adder datapath.

Parameters:
- ADDR_WIDTH, 11, width of RAM address.
- DRAIN_CYCLES, 4, cycles to wait after the last issued address before done (covers the delay stage plus datapath latency); legal range 1..15.

Ports:
- pll_clock  input  1  datapath clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first address of burst; latched on accepted start.
- count  input  ADDR_WIDTH+1  number of addresses to issue, 0..2^(ADDR_WIDTH+1)-1; latched on accepted start.
- stall  input  1  when high, no address is issued this cycle.
- addr_out  output  ADDR_WIDTH  registered address to the delay stage.
- e_out  output  1  registered enable; high only for cycles carrying a valid address.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, addr_out=0, e_out=0, busy=0, done=0, internal address and remaining/drain counters=0. Reset mid-burst abandons the burst; no done pulse.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE:
  - e_out=0; addr_out holds its last value.
  - start=1 with count>0: latch next_addr=base_addr, remaining=count, go RUN.
  - start=1 with count=0: go DONE directly; no e_out.
- RUN:
  - Each cycle with stall=0: addr_out<=next_addr, e_out<=1, next_addr<=next_addr+1 mod 2^ADDR_WIDTH, remaining<=remaining-1.
  - Each cycle with stall=1: e_out<=0; addr_out, next_addr and remaining hold.
  - When the issuing cycle has remaining=1: load drain counter=DRAIN_CYCLES, go DRAIN.
- DRAIN:
  - e_out=0; counter decrements each cycle regardless of stall.
  - On counter reaching 1, go DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency and timing:
  - Start accepted at edge t: first e_out=1 with addr_out=base_addr is visible after edge t+1 (no stall).
  - A burst of N addresses with no stall is issued on N consecutive cycles.
  - done rises DRAIN_CYCLES+1 cycles after the last e_out=1 cycle.
- Wrap-around: address increments past 2^ADDR_WIDTH-1 to 0. Counts above 2^ADDR_WIDTH revisit addresses, which is legal.
- start is ignored in RUN, DRAIN and DONE; no queuing. A start in the same cycle as done is ignored.
- start and stall in the same IDLE cycle: start is accepted; stall affects only RUN cycles.
- base_addr and count changes after acceptance have no effect on the running burst.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n low for 3 cycles, then high, 10 idle cycles.
  - Required: all outputs 0 throughout; busy=0, done=0.
- Basic burst:
  - Stimulus: base_addr=5, count=4, start pulse, no stall.
  - Required: e_out=1 for 4 consecutive cycles with addr_out=5,6,7,8, the first one cycle after start.
  - Required: done pulses once exactly 5 cycles (DRAIN_CYCLES+1) after the addr 8 cycle; busy high from first address through drain.
- Stall:
  - Stimulus: base_addr=0, count=3, stall high on the 2nd RUN cycle for 2 cycles.
  - Required: addr_out sequence 0, (held, e_out=0 x2), 1, 2; exactly 3 enable cycles; done timing measured from addr 2.
- Wrap:
  - Stimulus: base_addr=2046, count=4, ADDR_WIDTH=11.
  - Required: addr_out=2046, 2047, 0, 1.
- Zero count and ignored start:
  - Stimulus: count=0 with start.
  - Required: done pulse one cycle after start, no e_out.
  - Stimulus: second start pulse mid-burst.
  - Required: burst length unchanged; no second burst.
- Reset mid-burst:
  - Stimulus: base_addr=10, count=20, assert reset_n after 5 addresses.
  - Required: outputs 0 immediately (asynchronous); no done; next start with base_addr=0, count=2 gives addresses 0, 1 normally.

Source files
------------

// File: rtl/addr_sequencer.sv
// Burst address sequencer for the operand/result RAM path: it issues consecutive
// addresses with a per-address enable, honours stall, then drains and pulses done.
module addr_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                  pll_clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  e_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] next_addr, next_addr_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ADDR_WIDTH:0]   remaining, remaining_nxt;
  logic [3:0]            drain_cnt, drain_nxt;
  logic                  e_nxt, busy_nxt, done_nxt;

  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      next_addr <= '0;
      remaining <= '0;
      drain_cnt <= '0;
      addr_out  <= '0;
      e_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      next_addr <= next_addr_nxt;
      remaining <= remaining_nxt;
      drain_cnt <= drain_nxt;
      addr_out  <= addr_nxt;
      e_out     <= e_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    next_addr_nxt = next_addr;
    remaining_nxt = remaining;
    drain_nxt     = drain_cnt;
    addr_nxt      = addr_out;
    e_nxt         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            next_addr_nxt = base_addr;
            remaining_nxt = count;
            state_nxt     = RUN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          addr_nxt      = next_addr;
          e_nxt         = 1'b1;
          next_addr_nxt = next_addr + ADDR_WIDTH'(1);
          remaining_nxt = remaining - (ADDR_WIDTH + 1)'(1);
          if (remaining == (ADDR_WIDTH + 1)'(1)) begin
            drain_nxt = DRAIN_LOAD;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Counting down to zero (not one) because done is registered off the
        // next state: this lands done DRAIN_CYCLES+1 cycles after the last enable.
        if (drain_cnt == '0) begin
          state_nxt = DONE;
        end else begin
          drain_nxt = drain_cnt - 4'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed self-checking bench for addr_sequencer with hand-computed expectations.
module tb_addr_sequencer;

  localparam int unsigned AW = 11;
  localparam int unsigned D  = 4;

  logic          pll_clock = 1'b0;
  logic          reset_n   = 1'b0;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count     = '0;
  logic          stall     = 1'b0;
  logic [AW-1:0] addr_out;
  logic          e_out;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  addr_sequencer #(.ADDR_WIDTH(AW), .DRAIN_CYCLES(D)) dut (
    .pll_clock (pll_clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .stall     (stall),
    .addr_out  (addr_out),
    .e_out     (e_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 pll_clock = ~pll_clock;

  task automatic tick();
    @(posedge pll_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int a, input int e, input int b, input int d);
    chk({tag, ".addr"}, 32'(addr_out), a);
    chk({tag, ".e"},    32'(e_out),    e);
    chk({tag, ".busy"}, 32'(busy),     b);
    chk({tag, ".done"}, 32'(done),     d);
  endtask

  // Called right after the tick that showed the last enable.
  task automatic drain_and_done(input string tag, input int last);
    for (int i = 0; i < D; i++) begin
      tick();
      chk_out({tag, ".drain"}, last, 0, 1, 0);
    end
    tick();
    chk_out({tag, ".done"}, last, 0, 0, 1);
    tick();
    chk_out({tag, ".after"}, last, 0, 0, 0);
  endtask

  initial begin
    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset", 0, 0, 0, 0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("idle", 0, 0, 0, 0);
    end

    // Basic burst: 5,6,7,8
    base_addr = 11'd5; count = 12'd4; start = 1'b1;
    tick();
    start = 1'b0; base_addr = 11'd99; count = 12'd50;
    chk_out("basic.accept", 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("basic.issue", 5 + i, 1, 1, 0);
    end
    drain_and_done("basic", 8);

    // Stall on 2nd RUN cycle for 2 cycles: 0, hold, hold, 1, 2
    base_addr = 11'd0; count = 12'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("stall.accept", 8, 0, 1, 0);
    tick();
    chk_out("stall.a0", 0, 1, 1, 0);
    stall = 1'b1;
    tick();
    chk_out("stall.hold1", 0, 0, 1, 0);
    tick();
    chk_out("stall.hold2", 0, 0, 1, 0);
    stall = 1'b0;
    tick();
    chk_out("stall.a1", 1, 1, 1, 0);
    tick();
    chk_out("stall.a2", 2, 1, 1, 0);
    drain_and_done("stall", 2);

    // Start with stall in IDLE is accepted; count=1 boundary
    base_addr = 11'd33; count = 12'd1; start = 1'b1; stall = 1'b1;
    tick();
    start = 1'b0; stall = 1'b0;
    chk_out("one.accept", 2, 0, 1, 0);
    tick();
    chk_out("one.a", 33, 1, 1, 0);
    drain_and_done("one", 33);

    // Wrap-around with an ignored start mid-burst
    base_addr = 11'd2046; count = 12'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("wrap.accept", 33, 0, 1, 0);
    tick();
    chk_out("wrap.a0", 2046, 1, 1, 0);
    tick();
    chk_out("wrap.a1", 2047, 1, 1, 0);
    base_addr = 11'd100; count = 12'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("wrap.a2", 0, 1, 1, 0);
    tick();
    chk_out("wrap.a3", 1, 1, 1, 0);
    drain_and_done("wrap", 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("wrap.no_second", 1, 0, 0, 0);
    end

    // Zero count, then a start in the done cycle is ignored
    base_addr = 11'd7; count = 12'd0; start = 1'b1;
    tick();
    count = 12'd3;
    chk_out("zero.done", 1, 0, 0, 1);
    tick();
    start = 1'b0;
    chk_out("zero.ignored", 1, 0, 0, 0);
    tick();
    chk_out("zero.idle", 1, 0, 0, 0);

    // Reset mid-burst
    base_addr = 11'd10; count = 12'd20; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("rst.accept", 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("rst.issue", 10 + i, 1, 1, 0);
    end
    #2 reset_n = 1'b0;
    #1 chk_out("rst.async", 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("rst.held", 0, 0, 0, 0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("rst.no_done", 0, 0, 0, 0);
    end
    base_addr = 11'd0; count = 12'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("rst2.accept", 0, 0, 1, 0);
    tick();
    chk_out("rst2.a0", 0, 1, 1, 0);
    tick();
    chk_out("rst2.a1", 1, 1, 1, 0);
    drain_and_done("rst2", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
